alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Command front-end and result stage for the 4-bit combinational ALU (func 00=AND, 01=OR, 10=SUB, 11=ADD).
- Buffers incoming operation commands in a small FIFO and issues them one at a time on registered func/a/b lines.
- Captures the ALU result and presents it downstream on a valid/ready interface with a zero flag.
- Placement: directly upstream of the ALU, which it drives, and directly downstream of it, since it consumes the ALU's c output.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >=2.
- WIDTH, 4, operand/result width; must equal the ALU width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept; = !full && !rst.
- in_func  input  2  operation code.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- alu_func  output  2  registered func to ALU.
- alu_a  output  WIDTH  registered a to ALU.
- alu_b  output  WIDTH  registered b to ALU.
- alu_c  input  WIDTH  ALU result (combinational from alu_*).
- out_valid  output  1  result held.
- out_ready  input  1  downstream accepts.
- out_c  output  WIDTH  captured result.
- out_func  output  2  func that produced out_c.
- out_zero  output  1  out_c == 0.
- fifo_count  output  clog2(DEPTH)+1  FIFO occupancy.
- done_cnt  output  8  completed handshakes, wraps 255->0.

Behaviour:
- Reset, synchronous: all registered outputs 0; FIFO empty; fifo_count=0; done_cnt=0; state IDLE; in_ready=0 while rst=1.
- Reset mid-operation discards FIFO contents, the in-flight op and any held result. No output handshake completes on a reset cycle.
- Push: in_valid && in_ready at an edge writes {in_func,in_a,in_b} into the FIFO.
  - in_ready depends only on registered full. A pop in the same cycle does not allow a push when full.
- Pop: only from registered non-empty state; no bypass. A command pushed at edge T is not popped before edge T+1.
- Simultaneous push and pop when not full: fifo_count unchanged. Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if FIFO non-empty, pop, load alu_func/alu_a/alu_b, go EXEC.
  - EXEC: capture out_c<=alu_c, out_func<=alu_func, out_zero<=(alu_c==0), out_valid<=1, go DONE.
  - DONE: hold out_* stable while out_valid && !out_ready. On out_ready:
    - done_cnt++.
    - If FIFO non-empty: pop, load alu_*, out_valid<=0, go EXEC.
    - Else: out_valid<=0, go IDLE.
- alu_* hold their last values when not loading.
- Latency: accepted at edge T -> alu_* at edge T+1 -> out_valid at edge T+2.
- Best-case throughput with out_ready=1: one result per 2 cycles.
- Arithmetic is performed by the ALU only; out_c is WIDTH bits. Carry/borrow is dropped and SUB wraps modulo 2^WIDTH.
- Ordering: results are emitted strictly in command acceptance order. No drops or duplicates.
- Total in flight = FIFO + 1 result. in_ready falls when fifo_count==DEPTH.

Test Plan:
- Reset then single AND: func=00, a=1100, b=1010, out_ready=1 -> alu_* at T+1; out_valid at T+2 with out_c=1000, out_func=00, out_zero=0; done_cnt=1.
- Wrap cases, back-to-back: SUB 0011-0101 -> out_c=1110; ADD 1000+1000 -> out_c=0000, out_zero=1; ADD 1001+1000 -> 0001.
  - out_valid pulses every 2 cycles; results in order.
- Backpressure: out_ready=0, offer 6 commands -> exactly 5 accepted, in_ready=0 with fifo_count=4, out_c stable.
  - Then out_ready=1 -> 5 results in order, done_cnt=5, fifo_count returns to 0.
- Simultaneous push/pop at fifo_count=2 -> count stays 2. At fifo_count=DEPTH with a pop -> in_ready still 0 that cycle, push refused.
- Reset mid-stream: rst=1 with fifo_count=3 and out_valid=1 -> next edge fifo_count=0, out_valid=0, done_cnt=0, in_ready=0 during reset, 1 after.
- done_cnt wrap: 256 completed ops -> done_cnt returns to 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command FIFO + issue/capture sequencer wrapped around a 4-function combinational ALU.
// Commands are issued one at a time on registered alu_* lines; results leave on a valid/ready port.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_func,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [1:0]               alu_func,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_c,
  output logic [1:0]               out_func,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               done_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [1:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       alu_func_q, alu_func_d, out_func_q, out_func_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, out_c_q, out_c_d;
  logic             out_valid_q, out_valid_d, out_zero_q, out_zero_d;
  logic [7:0]       done_cnt_q, done_cnt_d;
  logic             full, empty, push, pop;
  cmd_t             head;

  always_comb begin
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    in_ready    = !full && !rst;
    push        = in_valid && in_ready;
    pop         = 1'b0;
    head        = mem_q[rd_ptr_q];
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    alu_func_d  = alu_func_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    out_c_d     = out_c_q;
    out_func_d  = out_func_q;
    out_zero_d  = out_zero_q;
    out_valid_d = out_valid_q;
    done_cnt_d  = done_cnt_q;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        out_c_d     = alu_c;
        out_func_d  = alu_func_q;
        out_zero_d  = (alu_c == '0);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          done_cnt_d  = done_cnt_q + 8'd1;
          out_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pop decisions only look at registered occupancy, so a same-cycle push never bypasses.
    if (pop) begin
      alu_func_d = head.func;
      alu_a_d    = head.a;
      alu_b_d    = head.b;
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = '{func: in_func, a: in_a, b: in_b};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_func_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      out_c_q     <= '0;
      out_func_q  <= '0;
      out_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_func_q  <= alu_func_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      out_c_q     <= out_c_d;
      out_func_q  <= out_func_d;
      out_zero_q  <= out_zero_d;
      out_valid_q <= out_valid_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign alu_func   = alu_func_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign out_valid  = out_valid_q;
  assign out_c      = out_c_q;
  assign out_func   = out_func_q;
  assign out_zero   = out_zero_q;
  assign fifo_count = count_q;
  assign done_cnt   = done_cnt_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus a queue-based scoreboard of expected results.
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_ready;
  logic [1:0]       in_func = '0;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic [1:0]       alu_func;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic             out_valid, out_ready = 1'b0;
  logic [WIDTH-1:0] out_c;
  logic [1:0]       out_func;
  logic             out_zero;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [7:0]       done_cnt;

  int checks = 0;
  int errors = 0;
  int hs_total = 0;
  logic [7:0] done_model = '0;

  typedef struct { logic [1:0] f; logic [WIDTH-1:0] c; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_res(input logic [1:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int r;
    case (f)
      2'd0:    r = int'(a & b);
      2'd1:    r = int'(a | b);
      2'd2:    r = int'(a) - int'(b);
      default: r = int'(a) + int'(b);
    endcase
    return WIDTH'(r & ((1 << WIDTH) - 1));
  endfunction

  // The ALU the sequencer drives
  assign alu_c = ref_res(alu_func, alu_a, alu_b);

  alu_op_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_a(in_a), .in_b(in_b),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_func(out_func), .out_zero(out_zero),
    .fifo_count(fifo_count), .done_cnt(done_cnt)
  );

  // Scoreboard: sampled mid-cycle, i.e. with the values the next rising edge will see
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      done_model = '0;
    end else begin
      checks++;
      if (done_cnt !== done_model) begin
        errors++; $display("FAIL done_cnt_track got %0d want %0d", done_cnt, done_model);
      end
      if (out_valid) begin
        checks++;
        if (out_zero !== (out_c == '0)) begin
          errors++; $display("FAIL out_zero got %0b for out_c %0h", out_zero, out_c);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL spurious_result got c=%0h f=%0d with nothing expected", out_c, out_func);
        end else begin
          if (out_c !== exp_q[0].c || out_func !== exp_q[0].f) begin
            errors++;
            $display("FAIL result_order got c=%0h f=%0d want c=%0h f=%0d", out_c, out_func, exp_q[0].c, exp_q[0].f);
          end
          void'(exp_q.pop_front());
        end
        done_model = done_model + 8'd1;
        hs_total++;
      end
      if (in_valid && in_ready) exp_q.push_back('{f: in_func, c: ref_res(in_func, in_a, in_b)});
    end
  end

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== '0 || done_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_state got v=%0b cnt=%0d done=%0d want 0 0 0", out_valid, fifo_count, done_cnt);
    end
    checks++;
    if (alu_func !== 2'd0 || alu_a !== '0 || alu_b !== '0 || out_c !== '0 || out_func !== 2'd0 || out_zero !== 1'b0) begin
      errors++; $display("FAIL reset_regs got f=%0d a=%0h b=%0h c=%0h of=%0d z=%0b want all 0",
                         alu_func, alu_a, alu_b, out_c, out_func, out_zero);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_single_and();
    @(posedge clk); #1;
    in_valid = 1'b1; in_func = 2'd0; in_a = 4'b1100; in_b = 4'b1010; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL and_accept got cnt=%0d v=%0b want 1 0", fifo_count, out_valid);
    end
    @(negedge clk);
    checks++;
    if (alu_func !== 2'd0 || alu_a !== 4'b1100 || alu_b !== 4'b1010 || out_valid !== 1'b0) begin
      errors++; $display("FAIL and_issue got f=%0d a=%0h b=%0h v=%0b want 0 c a 0", alu_func, alu_a, alu_b, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_c !== 4'b1000 || out_func !== 2'd0 || out_zero !== 1'b0) begin
      errors++; $display("FAIL and_result got v=%0b c=%0h f=%0d z=%0b want 1 8 0 0", out_valid, out_c, out_func, out_zero);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || done_cnt !== 8'd1) begin
      errors++; $display("FAIL and_done got v=%0b done=%0d want 0 1", out_valid, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]       fs [3] = '{2'd2, 2'd3, 2'd3};
    logic [WIDTH-1:0] as [3] = '{4'b0011, 4'b1000, 4'b1001};
    logic [WIDTH-1:0] bs [3] = '{4'b0101, 4'b1000, 4'b1000};
    logic [WIDTH-1:0] wc [3] = '{4'b1110, 4'b0000, 4'b0001};
    logic             wz [3] = '{1'b0, 1'b1, 1'b0};
    int pos [$];
    int nv = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      in_valid = (cyc < 3);
      if (cyc < 3) begin in_func = fs[cyc]; in_a = as[cyc]; in_b = bs[cyc]; end
      @(negedge clk);
      if (out_valid) begin
        if (nv < 3) begin
          checks++;
          if (out_c !== wc[nv] || out_zero !== wz[nv]) begin
            errors++; $display("FAIL b2b_value%0d got c=%0h z=%0b want c=%0h z=%0b", nv, out_c, out_zero, wc[nv], wz[nv]);
          end
        end
        pos.push_back(cyc);
        nv++;
      end
    end
    checks++;
    if (nv != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nv); end
    else begin
      checks++;
      if (pos[1] - pos[0] != 2 || pos[2] - pos[1] != 2) begin
        errors++; $display("FAIL b2b_spacing got %0d,%0d want 2,2", pos[1] - pos[0], pos[2] - pos[1]);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0]       d0 = done_cnt;
    int               h0 = hs_total;
    int               k = 0;
    logic             held_ok = 1'b0;
    logic [WIDTH-1:0] held = '0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      in_valid = (k < 6);
      if (k < 6 && (cyc == 0 || !in_valid || k > 0)) ;
      @(negedge clk);
      if (in_valid && in_ready) begin
        k++;
        @(posedge clk); #1;
        in_func = 2'($urandom_range(3)); in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
        @(negedge clk);
        if (in_valid && in_ready) k++;
      end
      if (out_valid && !held_ok) begin held = out_c; held_ok = 1'b1; end
      if (held_ok) begin
        checks++;
        if (out_c !== held || out_valid !== 1'b1) begin
          errors++; $display("FAIL bp_stable got c=%0h v=%0b want c=%0h v=1", out_c, out_valid, held);
        end
      end
    end
    checks++;
    if (k != 5 || in_ready !== 1'b0 || fifo_count !== 3'd4) begin
      errors++; $display("FAIL bp_full got acc=%0d rdy=%0b cnt=%0d want 5 0 4", k, in_ready, fifo_count);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
      errors++; $display("FAIL bp_pop_no_push got rdy=%0b cnt=%0d want 0 4", in_ready, fifo_count);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd3) begin errors++; $display("FAIL bp_refused got cnt=%0d want 3", fifo_count); end
    drain();
    checks++;
    if (done_cnt !== d0 + 8'd5 || hs_total - h0 != 5 || fifo_count !== '0) begin
      errors++; $display("FAIL bp_drain got done=%0d hs=%0d cnt=%0d want %0d 5 0", done_cnt, hs_total - h0, fifo_count, d0 + 8'd5);
    end
  endtask

  task automatic test_simul_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_func = 2'($urandom_range(3)); in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd2 || out_valid !== 1'b1) begin
      errors++; $display("FAIL spp_setup got cnt=%0d v=%0b want 2 1", fifo_count, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_func = 2'($urandom_range(3)); in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd2) begin errors++; $display("FAIL spp_count got %0d want 2", fifo_count); end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_func = 2'($urandom_range(3)); in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_setup got cnt=%0d v=%0b want 3 1", fifo_count, out_valid);
    end
    @(posedge clk); #1 rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got %0b want 0", in_ready); end
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== '0 || out_valid !== 1'b0 || done_cnt !== 8'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_state got cnt=%0d v=%0b done=%0d rdy=%0b want 0 0 0 1",
                         fifo_count, out_valid, done_cnt, in_ready);
    end
    drain();
  endtask

  task automatic test_random();
    int h0 = hs_total;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(9) < 6);
      out_ready = ($urandom_range(9) < 6);
      in_func   = 2'($urandom_range(3));
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
    end
    drain();
    checks++;
    if (hs_total - h0 < 20) begin errors++; $display("FAIL random_activity got %0d results want >=20", hs_total - h0); end
  endtask

  task automatic test_done_wrap();
    int acc = 0;
    int n = 0;
    int h0;
    @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    h0 = hs_total;
    out_ready = 1'b1;
    while (acc < 256 && n < 2000) begin
      in_valid = 1'b1; in_func = 2'($urandom_range(3)); in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1; n++;
    end
    drain();
    checks++;
    if (hs_total - h0 != 256 || done_cnt !== 8'd0) begin
      errors++; $display("FAIL done_wrap got hs=%0d done=%0d want 256 0", hs_total - h0, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_and();
    test_back_to_back();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid();
    test_random();
    test_done_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
